// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared constants for the branch redirect controller: condition codes,
// jump types, FSM state encodings and a target alignment helper.
package branch_redirect_ctrl_pkg;

  localparam int BRANCH_COND_LENGTH = 3;

  localparam logic [BRANCH_COND_LENGTH-1:0] BRANCH_COND_EQ  = 3'b000;
  localparam logic [BRANCH_COND_LENGTH-1:0] BRANCH_COND_NE  = 3'b001;
  localparam logic [BRANCH_COND_LENGTH-1:0] BRANCH_COND_LT  = 3'b100;
  localparam logic [BRANCH_COND_LENGTH-1:0] BRANCH_COND_GE  = 3'b101;
  localparam logic [BRANCH_COND_LENGTH-1:0] BRANCH_COND_LTU = 3'b110;
  localparam logic [BRANCH_COND_LENGTH-1:0] BRANCH_COND_GEU = 3'b111;

  typedef enum logic [1:0] {
    JUMP_TYPE_COND = 2'b00,
    JUMP_TYPE_JAL  = 2'b01,
    JUMP_TYPE_JALR = 2'b10,
    JUMP_TYPE_RSVD = 2'b11
  } jump_type_e;

  typedef enum logic [1:0] {
    REDIR_ST_IDLE  = 2'b00,
    REDIR_ST_EVAL  = 2'b01,
    REDIR_ST_REDIR = 2'b10
  } redir_st_e;

  // Only bit 1 matters: targets are always halfword aligned by construction or JALR masking.
  function automatic logic target_misaligned(input logic [1:0] lsbs);
    return lsbs[1];
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Decode/IFU-facing bundle of the branch redirect controller.
// BRANCH_MISALIGN_EXC_EN adds the misaligned-target exception outputs.
interface branch_redirect_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int COND_W     = 3,
  parameter int CNT_W      = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_type;
  logic [COND_W-1:0]     in_cond;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_imm;
  logic [DATA_WIDTH-1:0] in_rs1;
  logic [DATA_WIDTH-1:0] in_rs2;
  logic                  kill;
  logic                  redir_valid;
  logic                  redir_ready;
  logic [DATA_WIDTH-1:0] redir_pc;
  logic                  flush;
  logic                  res_valid;
  logic                  res_taken;
  logic [CNT_W-1:0]      stat_branches;
  logic [CNT_W-1:0]      stat_taken;
`ifdef BRANCH_MISALIGN_EXC_EN
  logic                  exc_valid;
  logic [DATA_WIDTH-1:0] exc_tval;
`endif

  modport slave (
    input  in_valid, in_type, in_cond, in_pc, in_imm, in_rs1, in_rs2, kill, redir_ready,
`ifdef BRANCH_MISALIGN_EXC_EN
    output exc_valid, exc_tval,
`endif
    output in_ready, redir_valid, redir_pc, flush, res_valid, res_taken,
           stat_branches, stat_taken
  );

  modport master (
    output in_valid, in_type, in_cond, in_pc, in_imm, in_rs1, in_rs2, kill, redir_ready,
`ifdef BRANCH_MISALIGN_EXC_EN
    input  exc_valid, exc_tval,
`endif
    input  in_ready, redir_valid, redir_pc, flush, res_valid, res_taken,
           stat_branches, stat_taken
  );
endinterface

// File: rtl/branch_redirect_ctrl_cmp.sv
// Branch comparator: purely combinational, resolves one condition code on two operands.
// Undefined condition codes resolve as not taken.
module branch_redirect_ctrl_cmp
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int COND_W     = 3
) (
  input  logic [COND_W-1:0]     branch_op,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  output logic                  cond_branch_taken
);

  always_comb begin
    cond_branch_taken = 1'b0;
    case (branch_op)
      COND_W'(BRANCH_COND_EQ):  cond_branch_taken = (rs1 == rs2);
      COND_W'(BRANCH_COND_NE):  cond_branch_taken = (rs1 != rs2);
      COND_W'(BRANCH_COND_LT):  cond_branch_taken = ($signed(rs1) <  $signed(rs2));
      COND_W'(BRANCH_COND_GE):  cond_branch_taken = ($signed(rs1) >= $signed(rs2));
      COND_W'(BRANCH_COND_LTU): cond_branch_taken = (rs1 <  rs2);
      COND_W'(BRANCH_COND_GEU): cond_branch_taken = (rs1 >= rs2);
      default:                  cond_branch_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer: accept (IDLE) -> resolve (EVAL, 1 cycle) -> redirect handshake (REDIR, holds until redir_ready).
// kill aborts any state; BRANCH_MISALIGN_EXC_EN turns misaligned taken targets into an exception pulse.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int COND_W     = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_redirect_ctrl_if.slave bus
);

  redir_st_e             state_q;
  logic [1:0]            type_q;
  logic [COND_W-1:0]     cond_q;
  logic [DATA_WIDTH-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] redir_pc_q;
  logic                  flush_q;
  logic [CNT_W-1:0]      cnt_br_q, cnt_tk_q;

  logic                  cmp_taken;
  logic                  taken_d;
  logic                  go_redir_d;
  logic [DATA_WIDTH-1:0] target_d;
  logic [DATA_WIDTH-1:0] jalr_sum;

  branch_redirect_ctrl_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .COND_W    (COND_W)
  ) u_cmp (
    .branch_op        (cond_q),
    .rs1              (rs1_q),
    .rs2              (rs2_q),
    .cond_branch_taken(cmp_taken)
  );

  assign jalr_sum = rs1_q + imm_q;

  always_comb begin
    taken_d  = 1'b0;
    target_d = pc_q + imm_q;
    case (jump_type_e'(type_q))
      JUMP_TYPE_COND: taken_d = cmp_taken;
      JUMP_TYPE_JAL:  taken_d = 1'b1;
      JUMP_TYPE_JALR: begin
        taken_d  = 1'b1;
        target_d = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
      end
      default:        taken_d = 1'b0;
    endcase
  end

`ifdef BRANCH_MISALIGN_EXC_EN
  assign go_redir_d    = taken_d && !target_misaligned(target_d[1:0]);
  assign bus.exc_valid = (state_q == REDIR_ST_EVAL) && taken_d
                         && target_misaligned(target_d[1:0]) && !bus.kill;
  assign bus.exc_tval  = target_d;
`else
  assign go_redir_d    = taken_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REDIR_ST_IDLE;
      type_q     <= '0;
      cond_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      redir_pc_q <= '0;
      flush_q    <= 1'b0;
      cnt_br_q   <= '0;
      cnt_tk_q   <= '0;
    end else begin
      // An accepted redirect flushes even if kill lands in the same cycle.
      flush_q <= (state_q == REDIR_ST_REDIR) && bus.redir_ready;
      case (state_q)
        REDIR_ST_IDLE: begin
          if (bus.in_valid && !bus.kill) begin
            type_q  <= bus.in_type;
            cond_q  <= bus.in_cond;
            pc_q    <= bus.in_pc;
            imm_q   <= bus.in_imm;
            rs1_q   <= bus.in_rs1;
            rs2_q   <= bus.in_rs2;
            state_q <= REDIR_ST_EVAL;
          end
        end
        REDIR_ST_EVAL: begin
          cnt_br_q <= cnt_br_q + 1'b1;
          cnt_tk_q <= cnt_tk_q + CNT_W'(taken_d);
          if (go_redir_d && !bus.kill) begin
            redir_pc_q <= target_d;
            state_q    <= REDIR_ST_REDIR;
          end else begin
            state_q    <= REDIR_ST_IDLE;
          end
        end
        REDIR_ST_REDIR: begin
          if (bus.redir_ready || bus.kill) state_q <= REDIR_ST_IDLE;
        end
        default: state_q <= REDIR_ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (state_q == REDIR_ST_IDLE);
  assign bus.res_valid     = (state_q == REDIR_ST_EVAL);
  assign bus.res_taken     = (state_q == REDIR_ST_EVAL) && taken_d;
  assign bus.redir_valid   = (state_q == REDIR_ST_REDIR);
  assign bus.redir_pc      = redir_pc_q;
  assign bus.flush         = flush_q;
  assign bus.stat_branches = cnt_br_q;
  assign bus.stat_taken    = cnt_tk_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench: driver pushes reference outcomes per accepted op, a negedge monitor
// tracks the expected handshake phases from the observed inputs and compares every cycle.
module tb_branch_redirect_ctrl;
  localparam int DW = 32;
  localparam int CW = 3;
  localparam int NW = 8;  // narrow counters so the random run wraps them

  typedef struct {
    logic          taken;
    logic [DW-1:0] target;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.DATA_WIDTH(DW), .COND_W(CW), .CNT_W(NW)) bus ();
  branch_redirect_ctrl #(.DATA_WIDTH(DW), .COND_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_eval(input logic [1:0] ty, input logic [2:0] cd,
                                    input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                                    input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    exp_t e;
    e.taken  = 1'b0;
    e.target = pc + imm;
    case (ty)
      2'd0: case (cd)
        3'd0: e.taken = (r1 == r2);
        3'd1: e.taken = (r1 != r2);
        3'd4: e.taken = ($signed(r1) <  $signed(r2));
        3'd5: e.taken = ($signed(r1) >= $signed(r2));
        3'd6: e.taken = (r1 <  r2);
        3'd7: e.taken = (r1 >= r2);
        default: e.taken = 1'b0;
      endcase
      2'd1: e.taken = 1'b1;
      2'd2: begin
        e.taken  = 1'b1;
        e.target = (r1 + imm) & 32'hFFFF_FFFE;
      end
      default: e.taken = 1'b0;
    endcase
    return e;
  endfunction

  // Monitor state: what the current cycle must show, derived last negedge.
  logic          mon_en = 1'b0;
  logic          e_res, e_redir, e_flush;
  logic          n_res, n_redir, n_flush, mis;
  logic [DW-1:0] e_pc;
  logic [NW-1:0] e_br, e_tk;
  exp_t          cur;

  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 32'(bus.in_ready), 32'(!e_res && !e_redir));
      check("res_valid", 32'(bus.res_valid), 32'(e_res));
      check("redir_valid", 32'(bus.redir_valid), 32'(e_redir));
      check("flush", 32'(bus.flush), 32'(e_flush));
      check("stat_branches", 32'(bus.stat_branches), 32'(e_br));
      check("stat_taken", 32'(bus.stat_taken), 32'(e_tk));
      n_res   = 1'b0;
      n_redir = e_redir;
      n_flush = 1'b0;
      mis     = 1'b0;
      if (e_res) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_underflow: got resolve expected none at %0t", $time);
        end else begin
          cur = q.pop_front();
          check("res_taken", 32'(bus.res_taken), 32'(cur.taken));
          e_br = e_br + 1'b1;
          e_tk = e_tk + NW'(cur.taken);
          e_pc = cur.target;
`ifdef BRANCH_MISALIGN_EXC_EN
          mis = cur.taken && cur.target[1];
          check("exc_valid", 32'(bus.exc_valid), 32'(mis && !bus.kill));
          if (mis && !bus.kill) check("exc_tval", bus.exc_tval, cur.target);
`endif
          n_redir = cur.taken && !mis && !bus.kill;
        end
      end else begin
`ifdef BRANCH_MISALIGN_EXC_EN
        check("exc_idle", 32'(bus.exc_valid), 32'd0);
`endif
      end
      if (e_redir) begin
        check("redir_pc", bus.redir_pc, e_pc);
        if (bus.redir_ready) begin
          n_redir = 1'b0;
          n_flush = 1'b1;
        end else if (bus.kill) begin
          n_redir = 1'b0;
        end
      end
      if (!e_res && !e_redir && bus.in_valid && !bus.kill) n_res = 1'b1;
      if (rst) begin
        n_res = 1'b0; n_redir = 1'b0; n_flush = 1'b0;
        e_br = '0; e_tk = '0;
        q.delete();
      end
      e_res   = n_res;
      e_redir = n_redir;
      e_flush = n_flush;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ph: 0 none, 1 kill at accept, 2 kill in EVAL, 3 kill in REDIR, 4 rst in REDIR, 5 kill with redir_ready
  task automatic do_op(input logic [1:0] ty, input logic [2:0] cd, input logic [DW-1:0] pc,
                       input logic [DW-1:0] imm, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                       input int ph, input int stall);
    exp_t e;
    int   w;
    logic m;
    e = ref_eval(ty, cd, pc, imm, r1, r2);
    m = 1'b0;
`ifdef BRANCH_MISALIGN_EXC_EN
    m = e.taken && e.target[1];
`endif
    w = 0;
    while (!bus.in_ready && w < 20) begin
      cyc();
      w++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_type  = ty;
    bus.in_cond  = cd;
    bus.in_pc    = pc;
    bus.in_imm   = imm;
    bus.in_rs1   = r1;
    bus.in_rs2   = r2;
    bus.kill     = (ph == 1);
    if (ph != 1) q.push_back(e);
    cyc();
    bus.in_valid = 1'b0;
    bus.in_rs1   = $urandom;
    bus.in_rs2   = $urandom;
    bus.kill     = (ph == 2);
    cyc();
    bus.kill = 1'b0;
    if (ph == 1 || ph == 2 || !e.taken || m) return;
    for (int i = 0; i <= stall; i++) begin
      bus.redir_ready = (i == stall);
      if (i == stall) begin
        case (ph)
          3: begin bus.redir_ready = 1'b0; bus.kill = 1'b1; end
          4: begin bus.redir_ready = 1'b0; rst = 1'b1; end
          5: bus.kill = 1'b1;
          default: ;
        endcase
      end
      cyc();
    end
    bus.redir_ready = 1'b0;
    bus.kill        = 1'b0;
    if (rst) begin
      rst = 1'b0;
      check("rst_redir_pc", bus.redir_pc, 32'd0);
    end
  endtask

  initial begin
    int ph, r;
    logic [DW-1:0] a, b;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_type = '0; bus.in_cond = '0;
    bus.in_pc = '0; bus.in_imm = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.kill = 1'b0; bus.redir_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    e_res = 1'b0; e_redir = 1'b0; e_flush = 1'b0;
    e_br = '0; e_tk = '0; e_pc = '0;
    check("reset_redir_pc", bus.redir_pc, 32'd0);
    mon_en = 1'b1;
    cyc();

    do_op(2'd0, 3'd0, 32'h8000_0000, 32'h10, 32'd5, 32'd5, 0, 0);           // BEQ taken
    do_op(2'd0, 3'd4, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 0, 1);        // BLT taken
    do_op(2'd0, 3'd6, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 0, 0);        // BLTU not taken
    do_op(2'd2, 3'd0, 32'h0, 32'h0, 32'h8000_0103, 32'd0, 0, 4);           // JALR mask, stalled
    do_op(2'd0, 3'd0, 32'h200, 32'h8, 32'd7, 32'd7, 3, 2);                 // kill in REDIR
    do_op(2'd1, 3'd0, 32'h300, 32'h40, 32'd0, 32'd0, 0, 0);
    do_op(2'd1, 3'd0, 32'h400, 32'h4, 32'd0, 32'd0, 4, 1);                 // rst in REDIR
    do_op(2'd1, 3'd0, 32'h8000_0000, 32'h6, 32'd0, 32'd0, 0, 0);           // halfword target
    do_op(2'd1, 3'd0, 32'h500, 32'h8, 32'd0, 32'd0, 5, 2);                 // kill with accept
    do_op(2'd1, 3'd0, 32'h600, 32'h8, 32'd0, 32'd0, 1, 0);                 // kill at accept
    do_op(2'd1, 3'd0, 32'h700, 32'h8, 32'd0, 32'd0, 2, 0);                 // kill in EVAL
    do_op(2'd3, 3'd0, 32'h800, 32'h8, 32'd3, 32'd3, 0, 0);                 // reserved type
    do_op(2'd0, 3'd2, 32'h900, 32'h8, 32'd3, 32'd3, 0, 0);                 // undefined cond
    do_op(2'd0, 3'd7, 32'hFFFF_FFF0, 32'h20, 32'd9, 32'd9, 0, 0);          // target wraps

    for (int n = 0; n < 450; n++) begin
      r  = $urandom_range(0, 9);
      ph = (r <= 5) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 5;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      repeat ($urandom_range(0, 2)) cyc();
      do_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, a, b,
            ph, $urandom_range(0, 3));
    end
    repeat (4) cyc();
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
